// File: rtl/svm_host.sv
// svm_host: host-side driver for the svm classifier load/stream protocol.
// Holds alpha + NSVS weights, buffers (x,y) samples in a FIFO, runs the
// start/alpha/weights/stream session and counts returned labels.
// Optional build macro: SVM_HOST_ZERO_IDLE_EN -- zero alpha/weight/x/y
// outside their own phase instead of holding the last driven value.
module svm_host #(
  parameter int NSVS       = 6,
  parameter int ALPHA_BW   = 16,
  parameter int WEIGHT_BW  = 16,
  parameter int DATA_BW    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_BW     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [15:0]          cfg_wdata,
  input  logic                 run,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BW-1:0]   s_x,
  input  logic [DATA_BW-1:0]   s_y,
  output logic                 svm_start,
  output logic [ALPHA_BW-1:0]  svm_alpha,
  output logic [WEIGHT_BW-1:0] svm_weight,
  output logic                 svm_de,
  output logic [DATA_BW-1:0]   svm_x,
  output logic [DATA_BW-1:0]   svm_y,
  input  logic                 svm_de_out,
  input  logic                 svm_label,
  output logic                 busy,
  output logic                 lbl_valid,
  output logic                 lbl,
  output logic [CNT_BW-1:0]    lbl_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int OBW = 8;
  localparam logic [2:0]      ALPHA_ADDR = 3'(NSVS);
  localparam logic [2:0]      LAST_IDX   = 3'(NSVS - 1);
  localparam logic [2:0]      IDX_ONE    = 3'd1;
  localparam logic [AW-1:0]   PTR_ONE    = 1;
  localparam logic [AW:0]     CNT_ONE    = 1;
  localparam logic [AW:0]     FULL_CNT   = FIFO_DEPTH;
  localparam logic [OBW-1:0]  OUT_ONE    = 1;
  localparam logic [CNT_BW-1:0] LC_ONE   = 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WEIGHTS, S_STREAM, S_DRAIN} state_t;

  state_t                                   state_q, state_d;
  logic [2:0]                               idx_q, idx_d;
  logic [ALPHA_BW-1:0]                      alpha_q, alpha_d;
  logic [NSVS-1:0][WEIGHT_BW-1:0]           w_q, w_d;
  logic [FIFO_DEPTH-1:0][2*DATA_BW-1:0]     mem_q, mem_d;
  logic [AW-1:0]                            wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]                              fcnt_q, fcnt_d;
  logic [OBW-1:0]                           outst_q, outst_d;
  logic                                     s_ready_q, s_ready_d;
  logic                                     start_q, start_d;
  logic [ALPHA_BW-1:0]                      alpha_o_q, alpha_o_d;
  logic [WEIGHT_BW-1:0]                     weight_o_q, weight_o_d;
  logic                                     de_q, de_d;
  logic [DATA_BW-1:0]                       x_q, x_d, y_q, y_d;
  logic                                     busy_q, busy_d;
  logic                                     lbl_valid_q, lbl_valid_d;
  logic                                     lbl_q, lbl_d;
  logic [CNT_BW-1:0]                        lbl_count_q, lbl_count_d;
  logic                                     push, pop;

  // Next-state, FIFO bookkeeping, coefficient writes and registered outputs
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    alpha_d     = alpha_q;
    w_d         = w_q;
    mem_d       = mem_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    fcnt_d      = fcnt_q;
    outst_d     = outst_q;
    start_d     = 1'b0;
    de_d        = 1'b0;
`ifdef SVM_HOST_ZERO_IDLE_EN
    alpha_o_d   = '0;
    weight_o_d  = '0;
    x_d         = '0;
    y_d         = '0;
`else
    alpha_o_d   = alpha_o_q;
    weight_o_d  = weight_o_q;
    x_d         = x_q;
    y_d         = y_q;
`endif
    push        = s_valid && s_ready_q;
    pop         = (state_q == S_STREAM);

    // Coefficients are only writable between sessions
    if (cfg_we && state_q == S_IDLE) begin
      if (cfg_addr == ALPHA_ADDR)     alpha_d = cfg_wdata[ALPHA_BW-1:0];
      else if (cfg_addr < ALPHA_ADDR) w_d[cfg_addr] = cfg_wdata[WEIGHT_BW-1:0];
    end

    // Labels in flight: issue adds one, arrival removes one
    if (pop && !svm_de_out)      outst_d = outst_q + OUT_ONE;
    else if (!pop && svm_de_out) outst_d = outst_q - OUT_ONE;

    case (state_q)
      S_IDLE: begin
        if (run && fcnt_q != '0) begin
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        alpha_o_d = alpha_q;
        idx_d     = '0;
        state_d   = S_WEIGHTS;
      end
      S_WEIGHTS: begin
        weight_o_d = w_q[idx_q];
        if (idx_q == LAST_IDX) state_d = S_STREAM;
        else                   idx_d   = idx_q + IDX_ONE;
      end
      S_STREAM: begin
        de_d       = 1'b1;
        {x_d, y_d} = mem_q[rp_q];
        // Leave when this pop drains the FIFO or the host withdraws run
        if ((fcnt_q == CNT_ONE && !push) || !run) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outst_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wp_q] = {s_x, s_y};
      wp_d        = wp_q + PTR_ONE;
    end
    if (pop) rp_d = rp_q + PTR_ONE;
    if (push && !pop)      fcnt_d = fcnt_q + CNT_ONE;
    else if (!push && pop) fcnt_d = fcnt_q - CNT_ONE;
    s_ready_d = (fcnt_d != FULL_CNT);

    busy_d      = (state_d != S_IDLE);
    lbl_valid_d = svm_de_out;
    lbl_d       = svm_de_out ? svm_label : lbl_q;
    lbl_count_d = svm_de_out ? lbl_count_q + LC_ONE : lbl_count_q;
  end

  // Control/output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      alpha_q     <= '0;
      w_q         <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      fcnt_q      <= '0;
      outst_q     <= '0;
      s_ready_q   <= 1'b1;
      start_q     <= 1'b0;
      alpha_o_q   <= '0;
      weight_o_q  <= '0;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      busy_q      <= 1'b0;
      lbl_valid_q <= 1'b0;
      lbl_q       <= 1'b0;
      lbl_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      alpha_q     <= alpha_d;
      w_q         <= w_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      fcnt_q      <= fcnt_d;
      outst_q     <= outst_d;
      s_ready_q   <= s_ready_d;
      start_q     <= start_d;
      alpha_o_q   <= alpha_o_d;
      weight_o_q  <= weight_o_d;
      de_q        <= de_d;
      x_q         <= x_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
      lbl_valid_q <= lbl_valid_d;
      lbl_q       <= lbl_d;
      lbl_count_q <= lbl_count_d;
    end
  end

  // Sample storage; emptiness is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign s_ready    = s_ready_q;
  assign svm_start  = start_q;
  assign svm_alpha  = alpha_o_q;
  assign svm_weight = weight_o_q;
  assign svm_de     = de_q;
  assign svm_x      = x_q;
  assign svm_y      = y_q;
  assign busy       = busy_q;
  assign lbl_valid  = lbl_valid_q;
  assign lbl        = lbl_q;
  assign lbl_count  = lbl_count_q;
endmodule

// File: tb/tb_svm_host.sv
// Bench for svm_host: stimulus pushes expected samples/coefficients into a
// model; a negedge monitor checks session sequencing, samples and labels.
// A 4-cycle classifier stand-in returns label = x[0].
module tb_svm_host;
  localparam int NSVS = 6;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          reset, cfg_we, run, s_valid;
  logic [2:0]    cfg_addr;
  logic [15:0]   cfg_wdata;
  logic [DW-1:0] s_x, s_y;
  logic          s_ready, svm_start, svm_de, busy, lbl_valid, lbl;
  logic [15:0]   svm_alpha, svm_weight, lbl_count;
  logic [DW-1:0] svm_x, svm_y;
  logic          svm_de_out, svm_label;

  always #5 clk = ~clk;

  svm_host dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .run(run), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .svm_start(svm_start), .svm_alpha(svm_alpha),
    .svm_weight(svm_weight), .svm_de(svm_de), .svm_x(svm_x), .svm_y(svm_y),
    .svm_de_out(svm_de_out), .svm_label(svm_label), .busy(busy),
    .lbl_valid(lbl_valid), .lbl(lbl), .lbl_count(lbl_count)
  );

  // Classifier stand-in: DE_out four cycles after DE_in, label = x[0]
  logic [3:0] de_pipe, lb_pipe;
  always @(posedge clk) begin
    if (reset) begin
      de_pipe <= '0;
      lb_pipe <= '0;
    end else begin
      de_pipe <= {de_pipe[2:0], svm_de};
      lb_pipe <= {lb_pipe[2:0], svm_x[0]};
    end
  end
  assign svm_de_out = de_pipe[3];
  assign svm_label  = lb_pipe[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] x; logic [DW-1:0] y; } samp_t;
  typedef struct { logic l; int c; } lbl_t;
  samp_t       exp_s[$];
  lbl_t        exp_l[$];
  logic [15:0] exp_alpha;
  logic [15:0] exp_w[NSVS];
  int          lbl_seen = 0;
  int          t0 = -1;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: session sequence after each start, samples in order, labels
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (t0 >= 0) begin
          int d;
          d = cyc - t0;
          if (d == 1) begin
            chk("start_pulse", {31'd0, svm_start}, 32'd0);
            chk("alpha", {16'd0, svm_alpha}, {16'd0, exp_alpha});
          end else if (d >= 2 && d <= NSVS + 1) begin
            chk($sformatf("weight%0d", d - 2), {16'd0, svm_weight}, {16'd0, exp_w[d-2]});
          end else if (d == NSVS + 2) begin
            chk("first_de", {31'd0, svm_de}, 32'd1);
            t0 = -1;
          end
        end
        if (svm_start) t0 = cyc;
        if (svm_de) begin
          if (exp_s.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_sample: got x=%0h y=%0h expected none", svm_x, svm_y);
          end else begin
            samp_t e;
            lbl_t  le;
            e = exp_s.pop_front();
            chk("sample_x", {16'd0, svm_x}, {16'd0, e.x});
            chk("sample_y", {16'd0, svm_y}, {16'd0, e.y});
            le.l = e.x[0];
            le.c = cyc + 5;
            exp_l.push_back(le);
          end
        end
        if (lbl_valid) begin
          if (exp_l.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_label: got %0b expected none", lbl);
          end else begin
            lbl_t le;
            le = exp_l.pop_front();
            lbl_seen++;
            chk("lbl", {31'd0, lbl}, {31'd0, le.l});
            chk("lbl_cycle", cyc, le.c);
            chk("lbl_count_run", {16'd0, lbl_count}, lbl_seen);
          end
        end
      end
    end
  end

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] dat, input bit takes);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = dat;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (takes) begin
      if (a == 3'(NSVS)) exp_alpha = dat;
      else if (a < 3'(NSVS)) exp_w[a] = dat;
    end
  endtask

  task automatic push(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit acc);
    samp_t e;
    @(negedge clk);
    s_valid = 1'b1; s_x = x; s_y = y;
    chk("s_ready", {31'd0, s_ready}, {31'd0, acc});
    if (acc) begin
      e.x = x; e.y = y;
      exp_s.push_back(e);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int bound, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy !== val) begin
      checks++; errors++;
      $display("FAIL %s: busy stayed %0b, required %0b within %0d cycles", nm, busy, val, bound);
    end
  endtask

  // Full session with run held until the FIFO drains, then settle
  task automatic session(input string nm);
    @(negedge clk);
    run = 1'b1;
    wait_busy(1'b1, 10, {nm, "_busy_rise"});
    wait_busy(1'b0, 80, {nm, "_busy_fall"});
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    run = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0;
    exp_alpha = '0;
    for (int i = 0; i < NSVS; i++) exp_w[i] = '0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_start", {31'd0, svm_start}, 32'd0);
    chk("rst_alpha", {16'd0, svm_alpha}, 32'd0);
    chk("rst_weight", {16'd0, svm_weight}, 32'd0);
    chk("rst_de", {31'd0, svm_de}, 32'd0);
    chk("rst_xy", {svm_x, svm_y}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_lbl", {30'd0, lbl_valid, lbl}, 32'd0);
    chk("rst_lbl_count", {16'd0, lbl_count}, 32'd0);
    reset = 1'b0;

    // Basic session: alpha 0x1234, weights 1..6, three samples
    cfg_write(3'd6, 16'h1234, 1'b1);
    for (int i = 0; i < NSVS; i++) cfg_write(3'(i), 16'(i + 1), 1'b1);
    push(16'h0011, 16'h0021, 1'b1);
    push(16'h0012, 16'h0022, 1'b1);
    push(16'h0013, 16'h0023, 1'b1);
    session("basic");
    chk("basic_lbl_count", {16'd0, lbl_count}, 32'd3);
    chk("basic_drained", exp_s.size() + exp_l.size(), 32'd0);

    // Fill the FIFO: the ninth sample is refused
    for (int i = 0; i < 8; i++) push(16'(16'h0100 + i), 16'(16'h0200 + i), 1'b1);
    push(16'h0FFF, 16'h0EEE, 1'b0);
    session("full");
    chk("full_lbl_count", {16'd0, lbl_count}, 32'd11);
    chk("full_drained", exp_s.size() + exp_l.size(), 32'd0);

    // run withdrawn during the second stream cycle
    for (int i = 0; i < 8; i++) push(16'(16'h0301 + i), 16'(16'h0400 + i), 1'b1);
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 10 && !svm_start; i++) @(negedge clk);
    if (!svm_start) begin
      checks++; errors++;
      $display("FAIL stop_start: svm_start stayed 0, required 1");
    end
    repeat (NSVS + 2) @(posedge clk);
    #1 run = 1'b0;
    wait_busy(1'b0, 40, "stop_busy_fall");
    repeat (3) @(negedge clk);
    chk("stop_lbl_count", {16'd0, lbl_count}, 32'd13);
    chk("stop_left", exp_s.size(), 32'd6);

    // Resume: reload, remaining six stream; a write while busy is dropped
    @(negedge clk);
    run = 1'b1;
    wait_busy(1'b1, 10, "resume_busy_rise");
    cfg_write(3'd2, 16'h7FFF, 1'b0);
    wait_busy(1'b0, 80, "resume_busy_fall");
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("resume_lbl_count", {16'd0, lbl_count}, 32'd19);
    chk("resume_drained", exp_s.size() + exp_l.size(), 32'd0);

    // Out-of-range address ignored; alpha rewrite in IDLE takes; w[2] still 3
    cfg_write(3'd7, 16'hBEEF, 1'b0);
    cfg_write(3'd6, 16'h0ABC, 1'b1);
    push(16'h0031, 16'h0041, 1'b1);
    session("oldw");
    chk("oldw_lbl_count", {16'd0, lbl_count}, 32'd20);

    // Reset during STREAM flushes everything
    for (int i = 0; i < 4; i++) push(16'(16'h0500 + i), 16'(16'h0600 + i), 1'b1);
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 20 && !svm_de; i++) @(negedge clk);
    if (!svm_de) begin
      checks++; errors++;
      $display("FAIL mrst_de: svm_de stayed 0, required 1");
    end
    reset = 1'b1;
    run = 1'b0;
    @(posedge clk); #1;
    chk("mrst_de", {31'd0, svm_de}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("mrst_lbl_count", {16'd0, lbl_count}, 32'd0);
    reset = 1'b0;
    exp_s.delete();
    exp_l.delete();
    lbl_seen = 0;
    t0 = -1;
    exp_alpha = '0;
    for (int i = 0; i < NSVS; i++) exp_w[i] = '0;
    push(16'h0050, 16'h0060, 1'b1);
    session("post_rst");
    chk("post_rst_lbl_count", {16'd0, lbl_count}, 32'd1);
    chk("post_rst_drained", exp_s.size() + exp_l.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/svm_host.md
# svm_host

Host-side driver for the `svm` classifier's load/stream protocol. It holds the alpha and support-vector weight coefficients in a programmable register file and buffers incoming (x, y) samples in a FIFO. For each session it issues the `start`, alpha, and weight load sequence, then streams samples with `DE` asserted. It also collects the returned `label`/`DE_out` results and counts them.

## Interface

Parameters:
- `NSVS`, 6, number of support-vector weights loaded per session
- `ALPHA_BW`, 16, alpha width
- `WEIGHT_BW`, 16, weight width
- `DATA_BW`, 16, sample component width
- `FIFO_DEPTH`, 8, sample FIFO entries (power of two)
- `CNT_BW`, 16, label counter width

Ports (one clock; `reset` is synchronous, active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `cfg_we`  in  1  coefficient write strobe
- `cfg_addr`  in  3  0..NSVS-1 selects a weight; NSVS selects alpha
- `cfg_wdata`  in  16  coefficient value (low bits used)
- `run`  in  1  session enable (level)
- `s_valid`  in  1  sample valid
- `s_ready`  out  1  FIFO not full
- `s_x`, `s_y`  in  DATA_BW  sample components
- `svm_start`  out  1  classifier `start`
- `svm_alpha`  out  ALPHA_BW  classifier `alpha`
- `svm_weight`  out  WEIGHT_BW  classifier `weight`
- `svm_de`  out  1  classifier `DE_in`
- `svm_x`, `svm_y`  out  DATA_BW  classifier `data_x`/`data_y`
- `svm_de_out`  in  1  classifier `DE_out`
- `svm_label`  in  1  classifier `label`
- `busy`  out  1  session in progress (state ≠ IDLE)
- `lbl_valid`  out  1  one-cycle pulse per returned label
- `lbl`  out  1  captured label
- `lbl_count`  out  CNT_BW  total labels received, wraps

## Operation

- All protocol outputs are registered.
- Reset values:
  - every output 0 except `s_ready` = 1
  - FIFO empty; coefficient registers 0; `lbl_count` 0; state IDLE
- Coefficient writes:
  - `cfg_we` is accepted only in IDLE.
  - While `busy` = 1 the write is dropped.
  - An address above NSVS is ignored.
- FIFO:
  - Push when `s_valid && s_ready`.
  - `s_ready` = !full; push and pop may occur in the same cycle.
- FSM:
  - **IDLE**: when `run` = 1 and the FIFO is non-empty, drive `svm_start` = 1 for one cycle, then go to START.
  - **START**: drive `svm_alpha` = alpha register for one cycle, then go to WEIGHTS (index 0).
  - **WEIGHTS**: drive `svm_weight` = w[idx] for NSVS consecutive cycles, idx 0..NSVS-1; after idx = NSVS-1, go to STREAM.
  - **STREAM**:
    - Every cycle: pop the FIFO head onto `svm_x`/`svm_y` with `svm_de` = 1, and increment the outstanding counter.
    - Go to DRAIN if this pop empties the FIFO (counting a same-cycle push) or `run` = 0 in this cycle; the current sample is still issued.
    - The FIFO is guaranteed non-empty on STREAM entry because no pop occurs between IDLE and STREAM.
  - **DRAIN**: `svm_de` = 0; return to IDLE when the outstanding counter reaches 0.
- Because the classifier drops to IDLE whenever `DE` falls, every session performs a full reload.
- Label path:
  - On `svm_de_out` = 1: next cycle `lbl_valid` = 1, `lbl` = `svm_label`, `lbl_count` += 1.
  - Each label decrements the outstanding counter; an arrival in the same cycle as an issue leaves the counter unchanged.
- Reset mid-session: immediate return to IDLE; the FIFO is flushed and coefficients are cleared. The classifier shares the reset net.

## Timing

- `svm_start` at cycle T; `svm_alpha` valid at T+1; weights at T+2..T+1+NSVS; first sample at T+2+NSVS.
- Classifier latency is 4 cycles: a sample with `svm_de` at cycle S returns `svm_de_out` at S+4, giving `lbl_valid` at S+5.
- Samples within a session are contiguous, one per cycle, with no gaps.
- Session length is NSVS+2+N+drain cycles; DRAIN lasts 4 cycles after the last sample.
- `s_ready` reflects occupancy registered at the previous edge.

## Configuration

- `SVM_HOST_ZERO_IDLE_EN`:
  - Defined: `svm_alpha`, `svm_weight`, `svm_x`, `svm_y` are forced to 0 in every cycle outside their own phase (toggle suppression).
  - Undefined: these outputs hold their last driven value.
- Protocol timing is identical either way.

## Test plan

- Reset: assert `reset` 2 cycles → all outputs 0, `s_ready` = 1, `lbl_count` = 0.
- Program alpha = 0x1234 and weights 1..6, push 3 samples, `run` = 1:
  - one-cycle `svm_start`; alpha 0x1234 next cycle; weights 1..6 on 6 consecutive cycles
  - 3 `svm_de` cycles with samples in order
  - 3 `lbl_valid` pulses, each 5 cycles after its issue; `lbl_count` = 3; `busy` falls after the last label.
- Push 9 samples with `run` = 0 → `s_ready` low after the 8th; the 9th is not accepted; all 8 stream later in order.
- 8 samples queued, `run` dropped during the 2nd stream cycle → 2 samples issued, then DRAIN; with `run` re-asserted, a new session reloads alpha/weights and streams the remaining 6.
- `cfg_we` to addr 2 with 0x7FFF while `busy` → write dropped; the next session still drives the old w[2].
- `reset` during STREAM → next cycle `svm_de` = 0, state IDLE, FIFO empty, `s_ready` = 1, coefficients 0.
